// File: rtl/ysyx_24100005_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
//   arb_state_e    : sequencer state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   owner_e        : transaction owner encoding (IFU=0, LSU=1)
//   TimeoutDefault : default watchdog limit in cycles
package ysyx_24100005_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OwnerIfu = 1'b0,
      OwnerLsu = 1'b1
   } owner_e;

   localparam int unsigned TimeoutDefault = 255;
   localparam int unsigned DataW          = 32;
   localparam int unsigned MaskW          = 8;

endpackage

// File: rtl/ysyx_24100005_rr_arb2.sv
// Combinational two-way round-robin picker.
//   req   : request vector, bit 0 = IFU, bit 1 = LSU
//   last  : owner granted most recently; the other one wins a tie
//   grant : one-hot grant (all zero when nothing requests)
module ysyx_24100005_rr_arb2
   import ysyx_24100005_pkg::*;
(
   input  logic [1:0] req,
   input  owner_e     last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last == OwnerLsu) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares one memory port between the IFU and the LSU with a single outstanding
// transaction, round-robin tie breaking and a watchdog that turns a hung memory
// into an error response.
//   ifu_*  : IFU request (read only) and response pulse
//   lsu_*  : LSU request (read or write) and response pulse
//   rsp_*  : shared registered response data / error, valid with a *_rsp_valid
//   mem_*  : memory-side request (latched fields) and response
module ysyx_24100005_mem_arbiter
   import ysyx_24100005_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_rsp_valid,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DataW-1:0]  lsu_wdata,
   input  logic [MaskW-1:0]  lsu_wmask,
   output logic              lsu_rsp_valid,
   output logic [DataW-1:0]  rsp_data,
   output logic              rsp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DataW-1:0]  mem_wdata,
   output logic [MaskW-1:0]  mem_wmask,
   input  logic              mem_rsp_valid,
   input  logic [DataW-1:0]  mem_rsp_data
);

   // Counter must be able to hold TIMEOUT itself (ISSUE accepted on the expiry cycle).
   localparam int unsigned    WdW    = $clog2(TIMEOUT + 1);
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DataW-1:0]  wdata_q, wdata_d;
   logic [MaskW-1:0]  wmask_q, wmask_d;
   logic [WdW-1:0]    wd_q, wd_d;
   logic [DataW-1:0]  rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   logic [1:0] grant;
   logic       idle;
   logic       accept;
   logic       wd_expired;

   ysyx_24100005_rr_arb2 u_rr_arb2 (
      .req   ({lsu_req_valid, ifu_req_valid}),
      .last  (last_grant_q),
      .grant (grant)
   );

   assign idle       = (state_q == StIdle);
   assign accept     = idle && (grant != 2'b00);
   assign wd_expired = (wd_q >= WdLast);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      wd_d         = wd_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               owner_d      = grant[1] ? OwnerLsu : OwnerIfu;
               last_grant_d = owner_d;
               wd_d         = '0;
               state_d      = StIssue;
               if (grant[1]) begin
                  addr_d  = lsu_addr;
                  wen_d   = lsu_wen;
                  wdata_d = lsu_wdata;
                  wmask_d = lsu_wmask;
               end else begin
                  addr_d  = ifu_addr;
                  wen_d   = 1'b0;
                  wdata_d = '0;
                  wmask_d = '0;
               end
            end
         end
         StIssue: begin
            wd_d = wd_q + WdW'(1);
            // A handshake on the expiry cycle still counts: memory owes a response.
            if (mem_req_ready) begin
               state_d = StWait;
            end else if (wd_expired) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = StResp;
            end
         end
         StWait: begin
            wd_d = wd_q + WdW'(1);
            // Completion beats a simultaneous expiry.
            if (mem_rsp_valid) begin
               rsp_data_d = mem_rsp_data;
               rsp_err_d  = 1'b0;
               state_d    = StResp;
            end else if (wd_expired) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         owner_q      <= OwnerIfu;
         last_grant_q <= OwnerLsu;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         wd_q         <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         wd_q         <= wd_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign ifu_req_ready = idle && grant[0];
   assign lsu_req_ready = idle && grant[1];
   assign ifu_rsp_valid = (state_q == StResp) && (owner_q == OwnerIfu);
   assign lsu_rsp_valid = (state_q == StResp) && (owner_q == OwnerLsu);
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;
   assign mem_req_valid = (state_q == StIssue);
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (TIMEOUT = 8).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_ysyx_24100005_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [AW-1:0] ifu_addr;
   logic          lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_wen;
   logic [AW-1:0] lsu_addr;
   logic [31:0]   lsu_wdata;
   logic [7:0]    lsu_wmask;
   logic [31:0]   rsp_data;
   logic          rsp_err;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rsp_data;
   logic [7:0]    mem_wmask;

   int n_tests = 0;
   int n_fail  = 0;

   ysyx_24100005_mem_arbiter #(
      .ADDR_W  (AW),
      .TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_addr      (ifu_addr),
      .ifu_rsp_valid (ifu_rsp_valid),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_addr      (lsu_addr),
      .lsu_wen       (lsu_wen),
      .lsu_wdata     (lsu_wdata),
      .lsu_wmask     (lsu_wmask),
      .lsu_rsp_valid (lsu_rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      ifu_req_valid = 1'b0;
      ifu_addr      = '0;
      lsu_req_valid = 1'b0;
      lsu_addr      = '0;
      lsu_wen       = 1'b0;
      lsu_wdata     = '0;
      lsu_wmask     = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
   endtask

   // Accept already happened in the current cycle; serve ISSUE and WAIT with zero
   // wait states. Returns at the start of the RESP cycle.
   task automatic serve_fast(input logic [31:0] data);
      next_cycle;
      mem_req_ready = 1'b1;
      next_cycle;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = data;
      next_cycle;
      mem_rsp_valid = 1'b0;
   endtask

   initial begin
      bit exp_lsu;

      clear_inputs();
      // Reset state
      repeat (2) next_cycle;
      @(negedge clk);
      check_eq("rst_mem_req_valid", mem_req_valid, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_rsp_data", rsp_data, 0);
      check_eq("rst_rsp_err", rsp_err, 0);
      check_eq("rst_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
      check_eq("rst_req_readys", {ifu_req_ready, lsu_req_ready}, 0);
      next_cycle;
      rst = 1'b1;
      next_cycle;

      // Basic IFU read, exact cycle timing
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0000;
      @(negedge clk);
      check_eq("t1_c0_ifu_ready", ifu_req_ready, 1);
      check_eq("t1_c0_lsu_ready", lsu_req_ready, 0);
      next_cycle;
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      check_eq("t1_c1_mem_req_valid", mem_req_valid, 1);
      check_eq("t1_c1_mem_addr", mem_addr, 32'h8000_0000);
      check_eq("t1_c1_mem_wen_mask", {mem_wen, mem_wmask}, 0);
      next_cycle;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h0000_0013;
      @(negedge clk);
      check_eq("t1_c2_mem_req_valid", mem_req_valid, 0);
      check_eq("t1_c2_ifu_rsp_valid", ifu_rsp_valid, 0);
      next_cycle;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check_eq("t1_c3_ifu_rsp_valid", ifu_rsp_valid, 1);
      check_eq("t1_c3_lsu_rsp_valid", lsu_rsp_valid, 0);
      check_eq("t1_c3_rsp_data", rsp_data, 32'h13);
      check_eq("t1_c3_rsp_err", rsp_err, 0);
      next_cycle;
      @(negedge clk);
      check_eq("t1_c4_ifu_rsp_valid", ifu_rsp_valid, 0);

      // Ties after a fresh reset alternate IFU, LSU, IFU, LSU
      next_cycle;
      rst = 1'b0;
      next_cycle;
      rst = 1'b1;
      next_cycle;
      for (int i = 0; i < 4; i++) begin
         exp_lsu       = (i % 2) == 1;
         ifu_req_valid = 1'b1;
         lsu_req_valid = 1'b1;
         lsu_wen       = 1'b0;
         ifu_addr      = 32'h8000_0000 + 32'(i * 4);
         lsu_addr      = 32'h9000_0000 + 32'(i * 4);
         @(negedge clk);
         check_eq($sformatf("tie%0d_ifu_ready", i), ifu_req_ready, !exp_lsu);
         check_eq($sformatf("tie%0d_lsu_ready", i), lsu_req_ready, exp_lsu);
         serve_fast(32'h100 + 32'(i));
         @(negedge clk);
         check_eq($sformatf("tie%0d_rsp_valids", i), {ifu_rsp_valid, lsu_rsp_valid},
                  exp_lsu ? 2'b01 : 2'b10);
         check_eq($sformatf("tie%0d_rsp_data", i), rsp_data, 32'h100 + 32'(i));
         check_eq($sformatf("tie%0d_resp_readys", i), {ifu_req_ready, lsu_req_ready}, 0);
         next_cycle;
      end
      clear_inputs();

      // LSU write with mem_req_ready held low for 5 cycles
      lsu_req_valid = 1'b1;
      lsu_wen       = 1'b1;
      lsu_addr      = 32'h8000_0100;
      lsu_wdata     = 32'hDEAD_BEEF;
      lsu_wmask     = 8'h0F;
      @(negedge clk);
      check_eq("wr_lsu_ready", lsu_req_ready, 1);
      check_eq("wr_ifu_ready", ifu_req_ready, 0);
      next_cycle;
      // Scramble the LSU inputs to prove the memory side is latched.
      lsu_req_valid = 1'b0;
      lsu_wen       = 1'b0;
      lsu_addr      = 32'h1111_1111;
      lsu_wdata     = 32'h2222_2222;
      lsu_wmask     = 8'hF0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq($sformatf("wr_stall%0d_valid", i), mem_req_valid, 1);
         check_eq($sformatf("wr_stall%0d_fields", i),
                  {mem_addr, mem_wdata}, {32'h8000_0100, 32'hDEAD_BEEF});
         check_eq($sformatf("wr_stall%0d_wen_mask", i), {mem_wen, mem_wmask}, {1'b1, 8'h0F});
         next_cycle;
      end
      mem_req_ready = 1'b1;
      next_cycle;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h1234_5678;
      next_cycle;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check_eq("wr_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 2'b01);
      check_eq("wr_rsp_data", rsp_data, 32'h1234_5678);
      check_eq("wr_rsp_err", rsp_err, 0);
      next_cycle;
      clear_inputs();

      // Timeout: accept in cycle 0, expiry in cycle 8, error pulse in cycle 9
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0200;
      @(negedge clk);
      check_eq("to_ifu_ready", ifu_req_ready, 1);
      next_cycle;
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      next_cycle;
      mem_req_ready = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         @(negedge clk);
         check_eq($sformatf("to_c%0d_no_rsp", c), ifu_rsp_valid, 0);
         next_cycle;
      end
      @(negedge clk);
      check_eq("to_c9_ifu_rsp_valid", ifu_rsp_valid, 1);
      check_eq("to_c9_rsp_err", rsp_err, 1);
      check_eq("to_c9_rsp_data", rsp_data, 0);
      next_cycle;
      for (int c = 10; c <= 14; c++) begin
         mem_rsp_valid = (c == 12);
         mem_rsp_data  = 32'hAAAA_AAAA;
         @(negedge clk);
         check_eq($sformatf("to_late_c%0d_rsp_valids", c), {ifu_rsp_valid, lsu_rsp_valid}, 0);
         check_eq($sformatf("to_late_c%0d_held", c), {rsp_err, rsp_data}, {1'b1, 32'h0});
         next_cycle;
      end
      clear_inputs();

      // Response in the exact expiry cycle wins
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0204;
      next_cycle;
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      next_cycle;
      mem_req_ready = 1'b0;
      repeat (6) next_cycle;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h0000_0055;
      next_cycle;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check_eq("edge_ifu_rsp_valid", ifu_rsp_valid, 1);
      check_eq("edge_rsp_err", rsp_err, 0);
      check_eq("edge_rsp_data", rsp_data, 32'h55);
      next_cycle;

      // Reset during WAIT aborts the transaction
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0300;
      next_cycle;
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      next_cycle;
      mem_req_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check_eq("rw_mem_addr", mem_addr, 0);
      check_eq("rw_rsp_data", rsp_data, 0);
      check_eq("rw_rsp_err", rsp_err, 0);
      check_eq("rw_valids", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 0);
      next_cycle;
      next_cycle;
      rst = 1'b1;
      @(negedge clk);
      check_eq("rw_post_no_stale", {ifu_rsp_valid, lsu_rsp_valid}, 0);
      next_cycle;
      // Tie right after reset: last grant is back to LSU, so IFU wins.
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0004;
      @(negedge clk);
      check_eq("rw_tie_readys", {ifu_req_ready, lsu_req_ready}, 2'b10);
      next_cycle;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      check_eq("rw_new_addr", mem_addr, 32'h8000_0004);
      next_cycle;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h0000_0093;
      next_cycle;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check_eq("rw_new_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 2'b10);
      check_eq("rw_new_rsp_data", rsp_data, 32'h93);
      check_eq("rw_new_rsp_err", rsp_err, 0);
      next_cycle;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
